// File: rtl/dma_pcie_axis_rq_arb.sv
// Round-robin packet arbiter for the PCIe RQ AXI-Stream path.
// Merges NUM_CH requester streams onto one master port. Grants are held for a
// whole packet so TLPs never interleave. A main/skid register pair drives the
// master port from flops and keeps m_tready off the s_tready path.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no packet in flight; pick the next valid channel
// LOCKED  | packet from grant_ch in progress; others held off
module dma_pcie_axis_rq_arb #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 137,
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int KW        = DATA_WIDTH / 32,
  localparam int GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         user_clk,
  input  logic                         user_reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH*USER_WIDTH-1:0] s_tuser,
  input  logic [NUM_CH*KW-1:0]         s_tkeep,
  input  logic [NUM_CH-1:0]            s_tlast,
  input  logic [NUM_CH-1:0]            s_tvalid,
  output logic [NUM_CH-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic [USER_WIDTH-1:0]        m_tuser,
  output logic [KW-1:0]                m_tkeep,
  output logic                         m_tlast,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [GW-1:0]                grant_ch,
  output logic [CNT_WIDTH-1:0]         pkt_count
);

  // One beat packed as {last, keep, user, data}.
  localparam int BW = 1 + KW + USER_WIDTH + DATA_WIDTH;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic [GW-1:0]        sel, src, rr_idx;
  logic                 sel_vld;
  logic                 buf_ready, accept, in_last;
  logic [BW-1:0]        in_beat;
  logic [BW-1:0]        main_q, main_d, skid_q, skid_d;
  logic                 main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Upstream is throttled only by skid occupancy (a flop), never by m_tready.
  assign buf_ready = ~skid_vld_q & ~user_reset;

  // Round-robin search starting just after the last completed grant.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    rr_idx  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_idx = GW'((int'(last_q) + k) % NUM_CH);
      if (!sel_vld && s_tvalid[rr_idx]) begin
        sel_vld = 1'b1;
        sel     = rr_idx;
      end
    end
  end

  // Source mux and per-channel ready: only the selected or locked channel may see ready.
  always_comb begin
    src      = (state_q == ST_IDLE) ? sel : grant_q;
    in_beat  = '0;
    s_tready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (src == GW'(k)) begin
        in_beat = {s_tlast[k], s_tkeep[k*KW +: KW], s_tuser[k*USER_WIDTH +: USER_WIDTH],
                   s_tdata[k*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
    if (state_q == ST_LOCKED) begin
      s_tready[grant_q] = buf_ready;
    end else if (sel_vld) begin
      s_tready[sel] = buf_ready;
    end
  end

  assign accept  = |(s_tvalid & s_tready);
  assign in_last = in_beat[BW-1];

  // Next-state logic: lock on a multi-beat packet, release on its last beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        grant_d = sel;
        if (in_last) begin
          last_d = sel;
        end else begin
          state_d = ST_LOCKED;
        end
      end else if (in_last) begin
        state_d = ST_IDLE;
        last_d  = grant_q;
      end
    end
  end

  // Main/skid buffer steering and output packet counter.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (accept) begin
      if (!main_vld_q || m_tready) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_beat;
        skid_vld_d = 1'b1;
      end
    end else if (main_vld_q && m_tready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = 1'b0;
      end
    end
    if (main_vld_q && m_tready && main_q[BW-1]) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State, grant and buffer registers; reset discards anything in flight.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      last_q     <= GW'(NUM_CH - 1);
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m_tdata   = main_q[DATA_WIDTH-1:0];
  assign m_tuser   = main_q[DATA_WIDTH +: USER_WIDTH];
  assign m_tkeep   = main_q[DATA_WIDTH+USER_WIDTH +: KW];
  assign m_tlast   = main_q[BW-1];
  assign m_tvalid  = main_vld_q;
  assign grant_ch  = grant_q;
  assign pkt_count = cnt_q;

endmodule

// File: doc/dma_pcie_axis_rq_arb.md
# dma_pcie_axis_rq_arb

Parametrised N-channel packet arbiter for the PCIe AXI-Stream requester-request (RQ) path. Merges up to 8 upstream RQ streams (descriptor engines, MSI-X, user bypass) onto one RQ master port toward the CPM. Grants are round-robin at packet granularity, so TLPs never interleave. A two-entry skid buffer on the output registers all master-side outputs and breaks the tready timing path.

## Interface
Parameters:
- DATA_WIDTH, 512, beat width in bits; multiple of 32 (256 and 512 supported).
- USER_WIDTH, 137, tuser width; carried unmodified.
- NUM_CH, 4, number of slave channels, 1..8.
- CNT_WIDTH, 16, width of the output packet counter.

Ports. Slave vectors are flattened, channel i occupies slice i.
- user_clk  in  1  sole clock; all logic on rising edge.
- user_reset  in  1  synchronous, active-high reset.
- s_tdata  in  NUM_CH*DATA_WIDTH  per-channel beat data.
- s_tuser  in  NUM_CH*USER_WIDTH  per-channel sideband.
- s_tkeep  in  NUM_CH*(DATA_WIDTH/32)  per-channel dword enables.
- s_tlast  in  NUM_CH  end of packet.
- s_tvalid  in  NUM_CH  beat valid.
- s_tready  out  NUM_CH  beat accepted; at most one bit high per cycle.
- m_tdata  out  DATA_WIDTH  merged RQ data.
- m_tuser  out  USER_WIDTH  merged sideband.
- m_tkeep  out  DATA_WIDTH/32  merged dword enables.
- m_tlast  out  1  end of packet.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- grant_ch  out  $clog2(NUM_CH), min 1  channel owning the current or last packet.
- pkt_count  out  CNT_WIDTH  count of packets completed on the master port.

## Operation
- Two FSM states:
  - IDLE: no packet in flight.
  - LOCKED: a packet from grant_ch is in progress.
- IDLE behaviour:
  - Combinationally select the first channel with s_tvalid=1, searching from (last_grant+1) mod NUM_CH upward with wrap.
  - s_tready of the selected channel equals buf_ready in the same cycle.
- A beat is accepted when s_tvalid[i] and s_tready[i] are both high.
  - Accepted beat with s_tlast=0: move to LOCKED; register grant_ch=i.
  - Accepted beat with s_tlast=1 (single-beat packet): stay IDLE; update grant_ch and last_grant to i.
- LOCKED behaviour:
  - Only s_tready[grant_ch] may assert, equal to buf_ready.
  - Other channels are held off regardless of their s_tvalid.
  - Accepted beat with tlast=1: return to IDLE; set last_grant=grant_ch.
- buf_ready = ~skid_valid, taken from a register.
- Skid buffer has a main register (drives m_*) and a skid register.
  - Accepted beat goes to main if main is empty or is draining this cycle (m_tready=1).
  - Otherwise the beat goes to skid.
  - When main drains and skid is full, skid moves to main.
- tdata, tuser, tkeep and tlast pass bit-exact; tkeep is not checked or modified.
- pkt_count increments by 1 on each m_tvalid & m_tready & m_tlast. It wraps from 2^CNT_WIDTH-1 to 0.
- NUM_CH=1: arbitration is degenerate, grant_ch stays 0, and the block acts as a registered pipe.
- Out-of-protocol input (s_tvalid dropped mid-packet on the granted channel): remain LOCKED and wait; no timeout.

## Timing
- Reset state:
  - Outputs: m_tvalid=0, m_tlast=0, m_tdata/m_tuser/m_tkeep=0, s_tready=0, grant_ch=0, pkt_count=0.
  - Internal: FSM=IDLE, skid empty, last_grant=NUM_CH-1, so channel 0 wins the first arbitration.
- First cycle after reset deassertion: s_tready may assert.
- Latency: a beat accepted in cycle N appears on m_* in cycle N+1 when main is empty.
- Throughput:
  - One beat per cycle with m_tready held high.
  - Zero bubble between back-to-back packets from different channels.
- m_* are driven only from flops; m_tready has no combinational path to any s_tready.
- m_tvalid, once high, holds with stable data until m_tready=1 (AXIS rule).
- Simultaneous load of skid and drain of main cannot occur: skid full forces buf_ready=0.
- Reset asserted mid-packet:
  - In-flight and buffered beats are discarded and all outputs return to reset values next cycle.
  - Upstream must restart packets.

## Test plan
- Single channel, 3-beat packet (NUM_CH=4, ch2 only), m_tready=1 -> beats on m_* at cycles N+1..N+3, m_tlast on the 3rd, grant_ch=2, pkt_count=1.
- All 4 channels issue a 2-beat packet every cycle from reset -> output order ch0,ch1,ch2,ch3,ch0; no interleaving; continuous m_tvalid; pkt_count=5 after 10 beats.
- m_tready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated, s_tready low while skid is full, data order preserved.
- Channels 1 and 3 each send 1-beat packets continuously -> strict alternation 1,3,1,3; FSM never enters LOCKED.
- ch0 is mid-packet after 2 of 4 beats when ch1 asserts valid -> s_tready[1]=0 until ch0's tlast is accepted; ch1's first beat follows with no gap.
- CNT_WIDTH=4 with 17 packets -> pkt_count wraps 15->0 and reads 1. A separate reset pulse mid-packet returns all outputs to 0 next cycle, and ch0 is granted first after release.
